// File: rtl/cacheline_burst_adaptor_if.sv
// Bus bundle between the line-side arbiter, the burst adaptor and physical memory.
// The adaptor uses the slave view; whatever drives requests and serves beats uses master.
interface cacheline_burst_adaptor_if #(
   parameter int s_offset    = 5,
   parameter int size        = (2**s_offset)*8,
   parameter int burst_width = 64
);
   // arbiter side
   logic [size-1:0]        line_i;
   logic [size-1:0]        line_o;
   logic [31:0]            address_i;
   logic                   read_i;
   logic                   write_i;
   logic                   resp_o;
   // memory side
   logic [burst_width-1:0] burst_i;
   logic [burst_width-1:0] burst_o;
   logic [31:0]            address_o;
   logic                   read_o;
   logic                   write_o;
   logic                   resp_i;

   modport slave (
      input  line_i, address_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, burst_o, address_o, read_o, write_o
   );

   modport master (
      output line_i, address_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, burst_o, address_o, read_o, write_o
   );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Converts one full-cacheline request into a fixed-length burst of narrow memory
// beats: writes are sliced out of a latched copy of the line, reads are assembled
// slot by slot, and a one-cycle resp_o closes the transaction.
module cacheline_burst_adaptor #(
   parameter int s_offset    = 5,
   parameter int size        = (2**s_offset)*8,
   parameter int burst_width = 64
) (
   input logic                      clk,
   input logic                      rst,
   cacheline_burst_adaptor_if.slave bus
);
   localparam int beats = size / burst_width;
   localparam int CNT_W = (beats > 1) ? $clog2(beats) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(beats - 1);
   // clears the byte-offset-within-line bits of the request address
   localparam logic [31:0] ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

   state_t                                 state_q, state_d;
   logic [CNT_W-1:0]                       cnt_q, cnt_d;
   logic [31:0]                            addr_q, addr_d;
   logic [beats-1:0][burst_width-1:0]      wline_q, wline_d;
   logic [beats-1:0][burst_width-1:0]      rline_q, rline_d;
   logic                                   last_beat;

   // a strobe on the final slot ends the burst and rewinds the counter
   assign last_beat = bus.resp_i && (cnt_q == LAST_BEAT);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next-state: read has priority; bursts always run to completion once started
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.read_i)       state_d = RD_BURST;
            else if (bus.write_i) state_d = WR_BURST;
         end
         RD_BURST: if (last_beat) state_d = DONE;
         WR_BURST: if (last_beat) state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // datapath next-state: request capture in IDLE, beat counting and read assembly in bursts
   always_comb begin
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wline_d = wline_q;
      rline_d = rline_q;
      case (state_q)
         IDLE: begin
            if (bus.read_i) begin
               addr_d = bus.address_i & ADDR_MASK;
               cnt_d  = '0;
            end else if (bus.write_i) begin
               addr_d  = bus.address_i & ADDR_MASK;
               wline_d = bus.line_i;
               cnt_d   = '0;
            end
         end
         RD_BURST: begin
            if (bus.resp_i) begin
               rline_d[cnt_q] = bus.burst_i;
               cnt_d          = last_beat ? '0 : cnt_q + CNT_W'(1);
            end
         end
         WR_BURST: begin
            if (bus.resp_i) cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   // datapath registers; the assembled read line is only ever touched by read beats
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         addr_q  <= '0;
         wline_q <= '0;
         rline_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wline_q <= wline_d;
         rline_q <= rline_d;
      end
   end

   // outputs decoded from state; address/beat buses are zero outside their burst
   always_comb begin
      bus.read_o    = 1'b0;
      bus.write_o   = 1'b0;
      bus.resp_o    = 1'b0;
      bus.address_o = '0;
      bus.burst_o   = '0;
      case (state_q)
         RD_BURST: begin
            bus.read_o    = 1'b1;
            bus.address_o = addr_q;
         end
         WR_BURST: begin
            bus.write_o   = 1'b1;
            bus.address_o = addr_q;
            bus.burst_o   = wline_q[cnt_q];
         end
         DONE:    bus.resp_o = 1'b1;
         default: ;
      endcase
   end

   assign bus.line_o = rline_q;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Scoreboard bench: request tasks push expected beats and line responses into
// queues, a negedge monitor pops and compares whatever the adaptor presents.
module tb_cacheline_burst_adaptor;
   localparam int SO = 5;
   localparam int SZ = 256;
   localparam int BW = 64;
   localparam int NB = SZ / BW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cacheline_burst_adaptor_if #(.s_offset(SO), .size(SZ), .burst_width(BW)) bus();

   cacheline_burst_adaptor #(.s_offset(SO), .size(SZ), .burst_width(BW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0]   a;
      logic [BW-1:0] d;
   } wbeat_t;

   int            total = 0;
   int            bad   = 0;
   wbeat_t        wr_q[$];
   logic [31:0]   rd_q[$];
   logic [SZ-1:0] resp_q[$];
   logic [SZ-1:0] model_line;

   task automatic check(input string nm, input logic [SZ-1:0] got, input logic [SZ-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // line-aligned address: drop the byte offset within a 32-byte line
   function automatic logic [31:0] align(input logic [31:0] a);
      return a - (a % 32);
   endfunction

   function automatic logic [SZ-1:0] rand_line();
      logic [SZ-1:0] l;
      for (int k = 0; k < SZ/32; k++) l[32*k +: 32] = $urandom;
      return l;
   endfunction

   task automatic expect_read(input logic [31:0] addr, input logic [BW-1:0] bts [NB]);
      logic [SZ-1:0] l;
      l = '0;
      for (int i = 0; i < NB; i++) begin
         rd_q.push_back(align(addr));
         l = l | (SZ'(bts[i]) << (BW*i));
      end
      resp_q.push_back(l);
      model_line = l;
   endtask

   task automatic expect_write(input logic [31:0] addr, input logic [SZ-1:0] ln);
      wbeat_t w;
      for (int i = 0; i < NB; i++) begin
         w.a = align(addr);
         w.d = ln[BW*i +: BW];
         wr_q.push_back(w);
      end
      resp_q.push_back(model_line);
   endtask

   // memory side: gp[i] idle cycles before beat i, then one strobe cycle
   task automatic serve(input bit rd, input logic [BW-1:0] bts [NB], input int gp [NB], input bit drop1);
      for (int i = 0; i < NB; i++) begin
         for (int g = 0; g < gp[i]; g++) begin
            bus.resp_i  = 1'b0;
            bus.burst_i = {$urandom, $urandom};
            step();
         end
         bus.resp_i  = 1'b1;
         bus.burst_i = rd ? bts[i] : {$urandom, $urandom};
         step();
         bus.resp_i  = 1'b0;
         if (drop1 && i == 0) begin
            bus.read_i  = 1'b0;
            bus.write_i = 1'b0;
         end
      end
      check("resp_o_after_last_beat", SZ'(bus.resp_o), SZ'(1'b1));
   endtask

   task automatic txn(input bit rd, input logic [31:0] addr, input logic [SZ-1:0] ln,
                      input logic [BW-1:0] bts [NB], input int gp [NB], input bit drop1);
      bus.address_i = addr;
      bus.line_i    = ln;
      bus.read_i    = rd;
      bus.write_i   = !rd;
      if (rd) expect_read(addr, bts);
      else    expect_write(addr, ln);
      step();
      check("start_read_o", SZ'(bus.read_o), SZ'(rd));
      check("start_write_o", SZ'(bus.write_o), SZ'(!rd));
      serve(rd, bts, gp, drop1);
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      step();
      check("resp_o_single_pulse", SZ'(bus.resp_o), SZ'(1'b0));
   endtask

   // monitor: compare every presented beat and response against the queues
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.write_o) begin
            check("read_o_during_write", SZ'(bus.read_o), SZ'(1'b0));
            if (wr_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_write_beat: got addr %h data %h want none", bus.address_o, bus.burst_o);
            end else begin
               check("wr_address_o", SZ'(bus.address_o), SZ'(wr_q[0].a));
               check("wr_burst_o", SZ'(bus.burst_o), SZ'(wr_q[0].d));
               if (bus.resp_i) void'(wr_q.pop_front());
            end
         end else begin
            check("burst_o_zero_when_not_writing", SZ'(bus.burst_o), '0);
         end
         if (bus.read_o && bus.resp_i) begin
            if (rd_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_read_beat: got addr %h want none", bus.address_o);
            end else begin
               check("rd_address_o", SZ'(bus.address_o), SZ'(rd_q.pop_front()));
            end
         end
         if (!bus.read_o && !bus.write_o)
            check("address_o_zero_when_idle", SZ'(bus.address_o), '0);
         if (bus.resp_o) begin
            if (resp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_resp_o: got 1 want 0");
            end else begin
               check("line_o_at_resp", bus.line_o, resp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [BW-1:0] bts [NB];
      int            gp  [NB];
      int            gp0 [NB];
      logic [SZ-1:0] ln;
      logic [31:0]   addr;

      rst           = 1'b1;
      bus.line_i    = '0;
      bus.address_i = '0;
      bus.read_i    = 1'b0;
      bus.write_i   = 1'b0;
      bus.burst_i   = '0;
      bus.resp_i    = 1'b0;
      model_line    = '0;
      gp0           = '{0, 0, 0, 0};
      repeat (3) step();

      // reset state
      check("rst_read_o", SZ'(bus.read_o), '0);
      check("rst_write_o", SZ'(bus.write_o), '0);
      check("rst_resp_o", SZ'(bus.resp_o), '0);
      check("rst_line_o", bus.line_o, '0);
      check("rst_address_o", SZ'(bus.address_o), '0);
      check("rst_burst_o", SZ'(bus.burst_o), '0);
      rst = 1'b0;

      // stray strobes in IDLE do nothing
      bus.resp_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.burst_i = {$urandom, $urandom};
         step();
         check("stray_read_o", SZ'(bus.read_o), '0);
         check("stray_resp_o", SZ'(bus.resp_o), '0);
         check("stray_line_o", bus.line_o, model_line);
      end
      bus.resp_i = 1'b0;

      // back-to-back read beats
      bts = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
      txn(1'b1, 32'h0000_1234, '0, bts, gp0, 1'b0);
      check("directed_read_line",  bus.line_o,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

      // write with strobe pattern 1,0,0,1,1,0,1
      ln = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
      gp = '{0, 2, 0, 1};
      txn(1'b0, 32'h0000_0080, ln, bts, gp, 1'b0);
      check("write_keeps_line_o", bus.line_o, model_line);

      // simultaneous read_i and write_i: read first, held write follows
      addr = 32'h0000_0ABC;
      ln   = rand_line();
      for (int i = 0; i < NB; i++) bts[i] = {$urandom, $urandom};
      bus.address_i = addr;
      bus.line_i    = ln;
      bus.read_i    = 1'b1;
      bus.write_i   = 1'b1;
      expect_read(addr, bts);
      expect_write(addr, ln);
      step();
      check("both_read_o", SZ'(bus.read_o), SZ'(1'b1));
      check("both_write_o", SZ'(bus.write_o), '0);
      serve(1'b1, bts, gp0, 1'b0);
      bus.read_i = 1'b0;
      step();
      check("both_resp_pulse", SZ'(bus.resp_o), '0);
      step();
      check("held_write_starts", SZ'(bus.write_o), SZ'(1'b1));
      serve(1'b0, bts, gp0, 1'b0);
      bus.write_i = 1'b0;
      step();
      check("held_write_resp_pulse", SZ'(bus.resp_o), '0);

      // read_i dropped after the first beat
      for (int i = 0; i < NB; i++) bts[i] = {$urandom, $urandom};
      gp = '{0, 1, 2, 0};
      txn(1'b1, $urandom, '0, bts, gp, 1'b1);

      // reset two beats into a read
      addr          = 32'h0000_4567;
      bus.address_i = addr;
      bus.read_i    = 1'b1;
      rd_q.push_back(align(addr));
      rd_q.push_back(align(addr));
      step();
      bus.resp_i  = 1'b1;
      bus.burst_i = {$urandom, $urandom};
      step();
      bus.burst_i = {$urandom, $urandom};
      step();
      bus.resp_i = 1'b0;
      rst        = 1'b1;
      bus.read_i = 1'b0;
      step();
      check("midburst_rst_read_o", SZ'(bus.read_o), '0);
      check("midburst_rst_line_o", bus.line_o, '0);
      step();
      rst        = 1'b0;
      model_line = '0;
      for (int i = 0; i < NB; i++) bts[i] = {$urandom, $urandom};
      txn(1'b1, 32'h0000_9000, '0, bts, gp0, 1'b0);

      // randomized traffic
      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < NB; i++) begin
            bts[i] = {$urandom, $urandom};
            gp[i]  = $urandom_range(0, 3);
         end
         txn(1'($urandom_range(0, 1)), $urandom, rand_line(), bts, gp,
             1'($urandom_range(0, 3) == 0));
      end

      repeat (3) step();
      check("resp_q_drained", SZ'(resp_q.size()), '0);
      check("rd_q_drained", SZ'(rd_q.size()), '0);
      check("wr_q_drained", SZ'(wr_q.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // hard stop in case the sequence above ever stalls
   initial begin
      #200000;
      $display("FAIL timeout: got no end of sequence want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Sits directly downstream of the instruction/data arbiter; it consumes the arbiter's single full-cacheline request (address, read/write, line data) and drives the physical memory port.
- Physical memory moves one line as a fixed-length burst of narrow beats; the block serialises writes into beats and assembles read beats back into a line.
- Returns a single-cycle response to the arbiter once the whole burst is complete.

Parameters:
- s_offset, 5, log2 of line size in bytes; line width = (2**s_offset)*8.
- size, (2**s_offset)*8, cacheline width in bits (default 256).
- burst_width, 64, memory beat width in bits; beats = size/burst_width (default 4, must be an integer ≥2, derived localparam).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- line_i  in  size  write line from arbiter (pmem_wdata_c).
- line_o  out  size  assembled read line to arbiter (pmem_rdata_c).
- address_i  in  32  line address from arbiter.
- read_i  in  1  line read request, held until resp_o.
- write_i  in  1  line write request, held until resp_o.
- resp_o  out  1  line transaction complete, one-cycle pulse.
- burst_i  in  burst_width  read beat from memory.
- burst_o  out  burst_width  write beat to memory.
- address_o  out  32  burst address to memory.
- read_o  out  1  burst read request.
- write_o  out  1  burst write request.
- resp_i  in  1  memory beat valid/accepted strobe.

Behaviour:
- Reset (sync, active-high): state=IDLE, beat counter=0, latched address/line=0, line_o=0, all outputs 0. Reset in any state aborts the burst immediately; read_o/write_o are 0 the next cycle.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - read_o=write_o=resp_o=0.
  - If read_i is high, latch address_i with its low s_offset bits forced to 0, clear the counter, and go to RD_BURST.
  - Else if write_i is high, latch the same aligned address and line_i, and go to WR_BURST.
  - Read wins when read_i and write_i are high together.
- RD_BURST:
  - read_o=1, address_o=latched address.
  - On each cycle with resp_i=1, write burst_i into beat slot [cnt*burst_width +: burst_width] of line_o, then cnt++.
  - resp_i=0 cycles stall without advancing; gaps between beats are legal.
  - When resp_i=1 and cnt==beats-1, capture the final beat, clear cnt, and go to DONE.
- WR_BURST:
  - write_o=1, address_o=latched address, burst_o=latched line slot [cnt].
  - Each resp_i=1 means the current beat is accepted; cnt++.
  - When the last beat is accepted, clear cnt and go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0; then go to IDLE.
  - line_o is stable in DONE and holds until the next read completes. Writes never modify line_o.
- Latency:
  - Request sampled in IDLE → read_o/write_o high the next cycle.
  - resp_o is asserted the cycle after the last beat's resp_i.
  - Minimum total is beats+2 cycles from request to resp_o.
- Requester protocol:
  - Requester holds read_i/write_i and address_i/line_i stable until resp_o, then deasserts the next cycle.
  - Deassertion mid-burst is ignored; the burst always completes.
  - Request inputs are not sampled in RD_BURST, WR_BURST or DONE.
- resp_i in IDLE or DONE is ignored and produces no state or data change.
- address_o and burst_o are 0 whenever their respective request is not active.
- Counter width is clog2(beats); the counter never wraps inside a burst because it is cleared on the last beat.

Test Plan:
- Reset: rst=1 for 2 cycles mid-RD_BURST after 2 beats → next cycle read_o=0, line_o=0; a new read then assembles all 4 beats from slot 0.
- Read with back-to-back beats: address_i=0x0000_1234, read_i=1; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive resp_i → address_o=0x0000_1220; line_o={0x44..,0x33..,0x22..,0x11..}; resp_o is a single pulse exactly 1 cycle after the 4th beat.
- Write with stalls: line_i=256'h0123…CDEF at address 0x80; resp_i pattern 1,0,0,1,1,0,1 → burst_o steps through slots 0..3, changing only after each resp_i=1; write_o drops and resp_o pulses after the 4th accept; line_o is unchanged.
- Simultaneous read_i and write_i: both high in IDLE → read_o=1 and write_o=0; after completion, with write_i still high, a write burst starts from IDLE.
- Stray and dropped strobes: resp_i=1 in IDLE → no transition and no resp_o. read_i dropped after beat 1 → burst still completes and resp_o pulses once.
